// File: rtl/bus_pkg.sv
// Shared types and helpers for the CPU-to-slave memory interconnect.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP,
    ST_ERROR
  } bus_state_e;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

  // Index width that stays at least one bit wide for single-entry cases.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/bus_region_match.sv
// Combinational base/mask region decoder; the lowest matching index wins,
// then that region's fetch or data permission decides whether it is a hit.
module bus_region_match #(
  parameter int N_SLAVES   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int SEL_WIDTH  = 2
) (
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic                           instr,
  input  logic [N_SLAVES*ADDR_WIDTH-1:0] base,
  input  logic [N_SLAVES*ADDR_WIDTH-1:0] mask,
  input  logic [N_SLAVES-1:0]            instr_allow,
  input  logic [N_SLAVES-1:0]            data_allow,
  output logic                           hit,
  output logic [SEL_WIDTH-1:0]           sel,
  output logic [ADDR_WIDTH-1:0]          local_addr
);

  logic [ADDR_WIDTH-1:0] base_arr [N_SLAVES];
  logic [ADDR_WIDTH-1:0] mask_arr [N_SLAVES];
  logic [N_SLAVES-1:0]   match_vec;
  logic [N_SLAVES-1:0]   allow_vec;
  logic                  found;

  generate
    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_region
      assign base_arr[gi]  = base[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign mask_arr[gi]  = mask[gi*ADDR_WIDTH +: ADDR_WIDTH];
      // An all-zero mask marks an unused slot rather than a match-everything region.
      assign match_vec[gi] = (mask_arr[gi] != '0) &&
                             ((addr & mask_arr[gi]) == base_arr[gi]);
    end
  endgenerate

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (!found && match_vec[i]) begin
        found = 1'b1;
        sel   = SEL_WIDTH'(i);
      end
    end
  end

  assign allow_vec  = instr ? instr_allow : data_allow;
  assign hit        = found && allow_vec[sel];
  assign local_addr = addr & ~mask_arr[sel];

endmodule

// File: rtl/bus_interconnect.sv
// picorv32 native-port interconnect: registered one-hot slave select, per-slave
// ready/rdata mux, and error responses for unmapped, forbidden or stalled accesses.
module bus_interconnect
  import bus_pkg::*;
#(
  parameter int N_SLAVES   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h10000000, 32'h00001000, 32'h00000000, 32'h0},
  parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
    {32'hFFFFFFFC, 32'hFFFFF000, 32'hFFFFF000, 32'h0},
  parameter logic [N_SLAVES-1:0]   INSTR_ALLOW    = 4'b0001,
  parameter logic [N_SLAVES-1:0]   DATA_ALLOW     = 4'b0111,
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
  input  logic                           clk_in,
  input  logic                           reset_in,
  input  logic                           mem_valid,
  input  logic                           mem_instr,
  input  logic [ADDR_WIDTH-1:0]          mem_addr,
  input  logic [DATA_WIDTH-1:0]          mem_wdata,
  input  logic [DATA_WIDTH/8-1:0]        mem_wstrb,
  output logic                           mem_ready,
  output logic [DATA_WIDTH-1:0]          mem_rdata,
  output logic [N_SLAVES-1:0]            s_enable,
  output logic                           s_write,
  output logic [ADDR_WIDTH-1:0]          s_addr,
  output logic [DATA_WIDTH-1:0]          s_wdata,
  output logic [DATA_WIDTH/8-1:0]        s_wstrb,
  input  logic [N_SLAVES-1:0]            s_ready,
  input  logic [N_SLAVES*DATA_WIDTH-1:0] s_rdata,
  output logic                           bus_error,
  output logic [ADDR_WIDTH-1:0]          err_addr
);

  localparam int SEL_W = clog2_min1(N_SLAVES);
  localparam int CNT_W = clog2_min1(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  bus_state_e            state_reg;
  logic [SEL_W-1:0]      sel_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  match_hit;
  logic [SEL_W-1:0]      match_sel;
  logic [ADDR_WIDTH-1:0] match_local;
  logic [DATA_WIDTH-1:0] rdata_arr [N_SLAVES];

  generate
    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_rdata
      assign rdata_arr[gi] = s_rdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  bus_region_match #(
    .N_SLAVES   (N_SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SEL_WIDTH  (SEL_W)
  ) u_match (
    .addr        (mem_addr),
    .instr       (mem_instr),
    .base        (SLAVE_BASE),
    .mask        (SLAVE_MASK),
    .instr_allow (INSTR_ALLOW),
    .data_allow  (DATA_ALLOW),
    .hit         (match_hit),
    .sel         (match_sel),
    .local_addr  (match_local)
  );

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_reg <= ST_IDLE;
      sel_reg   <= '0;
      cnt_reg   <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      s_enable  <= '0;
      s_write   <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      bus_error <= 1'b0;
      err_addr  <= '0;
    end else begin
      mem_ready <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (mem_valid) begin
            if (match_hit) begin
              sel_reg   <= match_sel;
              s_enable  <= N_SLAVES'(1) << match_sel;
              s_write   <= |mem_wstrb;
              s_addr    <= match_local;
              s_wdata   <= mem_wdata;
              s_wstrb   <= mem_wstrb;
              cnt_reg   <= '0;
              state_reg <= ST_ACCESS;
            end else begin
              // The error response is registered on entry so it appears in the ERROR cycle.
              mem_ready <= 1'b1;
              mem_rdata <= ERR_DATA;
              bus_error <= 1'b1;
              if (!bus_error) err_addr <= mem_addr;
              state_reg <= ST_ERROR;
            end
          end
        end
        ST_ACCESS: begin
          if (!mem_valid) begin
            s_enable  <= '0;
            state_reg <= ST_IDLE;
          end else if (s_ready[sel_reg]) begin
            mem_rdata <= rdata_arr[sel_reg];
            mem_ready <= 1'b1;
            s_enable  <= '0;
            state_reg <= ST_RESP;
          end else if (cnt_reg == CNT_LAST) begin
            s_enable  <= '0;
            mem_ready <= 1'b1;
            mem_rdata <= ERR_DATA;
            bus_error <= 1'b1;
            if (!bus_error) err_addr <= mem_addr;
            state_reg <= ST_ERROR;
          end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_RESP:  state_reg <= ST_IDLE;
        ST_ERROR: state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_interconnect.sv
// Directed bench: rom/ram/io map, short timeout, hand-computed expectations.
module tb_bus_interconnect;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic           clk_in = 1'b0;
  logic           reset_in;
  logic           mem_valid;
  logic           mem_instr;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [3:0]     mem_wstrb;
  logic           mem_ready;
  logic [DW-1:0]  mem_rdata;
  logic [NS-1:0]  s_enable;
  logic           s_write;
  logic [AW-1:0]  s_addr;
  logic [DW-1:0]  s_wdata;
  logic [3:0]     s_wstrb;
  logic [NS-1:0]  s_ready;
  logic [NS*DW-1:0] s_rdata;
  logic           bus_error;
  logic [AW-1:0]  err_addr;

  int checks = 0;
  int failures = 0;

  // slot0 rom, slot1 ram, slot2 io, slot3 unused
  bus_interconnect #(
    .N_SLAVES       (NS),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .SLAVE_BASE     ({32'h0, 32'h10000000, 32'h00001000, 32'h00000000}),
    .SLAVE_MASK     ({32'h0, 32'hFFFFFFFC, 32'hFFFFF000, 32'hFFFFF000}),
    .INSTR_ALLOW    (4'b0001),
    .DATA_ALLOW     (4'b0111),
    .TIMEOUT_CYCLES (8),
    .ERR_DATA       (32'hDEADBEEF)
  ) dut (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .s_enable  (s_enable),
    .s_write   (s_write),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_ready   (s_ready),
    .s_rdata   (s_rdata),
    .bus_error (bus_error),
    .err_addr  (err_addr)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic request(input logic instr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    mem_valid = 1'b1;
    mem_instr = instr;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
  endtask

  task automatic idle_cpu();
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_wstrb = 4'b0000;
    s_ready   = '0;
  endtask

  initial begin
    s_rdata  = {32'hEEEE0004, 32'hC0C00003, 32'hB0B00002, 32'hA0A00001};
    reset_in = 1'b1;
    mem_addr = '0;
    mem_wdata = '0;
    idle_cpu();
    tick();
    tick();
    check("rst_enable", 32'(s_enable), 32'h0);
    check("rst_ready", 32'(mem_ready), 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_error", 32'(bus_error), 32'h0);
    check("rst_err_addr", err_addr, 32'h0);
    reset_in = 1'b0;
    tick();
    $display("step reset done");

    // rom fetch, slave ready in the enable cycle -> mem_ready at cycle 2
    request(1'b1, 32'h00000010, 32'h0, 4'b0000);
    check("fetch_c0_ready", 32'(mem_ready), 32'h0);
    tick();
    check("fetch_c1_enable", 32'(s_enable), 32'h1);
    check("fetch_c1_addr", s_addr, 32'h10);
    check("fetch_c1_write", 32'(s_write), 32'h0);
    check("fetch_c1_ready", 32'(mem_ready), 32'h0);
    s_ready = 4'b0001;
    tick();
    check("fetch_c2_ready", 32'(mem_ready), 32'h1);
    check("fetch_c2_rdata", mem_rdata, 32'hA0A00001);
    check("fetch_c2_enable", 32'(s_enable), 32'h0);
    idle_cpu();
    tick();
    check("fetch_c3_ready", 32'(mem_ready), 32'h0);
    $display("step rom fetch rdata=%h", mem_rdata);

    // io write; foreign ready bits ignored; slave ready at cycle 2
    request(1'b0, 32'h10000000, 32'h0000000F, 4'b0001);
    tick();
    check("wr_c1_enable", 32'(s_enable), 32'h4);
    check("wr_c1_write", 32'(s_write), 32'h1);
    check("wr_c1_wstrb", 32'(s_wstrb), 32'h1);
    check("wr_c1_wdata", s_wdata, 32'h0000000F);
    check("wr_c1_addr", s_addr, 32'h0);
    s_ready = 4'b0011;
    tick();
    check("wr_c2_foreign_ready", 32'(mem_ready), 32'h0);
    check("wr_c2_enable", 32'(s_enable), 32'h4);
    s_ready = 4'b0100;
    tick();
    check("wr_c3_ready", 32'(mem_ready), 32'h1);
    check("wr_c3_rdata", mem_rdata, 32'hC0C00003);
    check("wr_c3_error", 32'(bus_error), 32'h0);
    // back-to-back: next request presented in the response cycle
    s_ready = '0;
    request(1'b0, 32'h00001004, 32'h0, 4'b0000);
    tick();
    check("b2b_c4_enable", 32'(s_enable), 32'h0);
    check("b2b_c4_ready", 32'(mem_ready), 32'h0);
    tick();
    check("b2b_c5_enable", 32'(s_enable), 32'h2);
    check("b2b_c5_addr", s_addr, 32'h4);
    check("b2b_c5_write", 32'(s_write), 32'h0);
    s_ready = 4'b0010;
    tick();
    check("b2b_c6_ready", 32'(mem_ready), 32'h1);
    check("b2b_c6_rdata", mem_rdata, 32'hB0B00002);
    idle_cpu();
    tick();
    $display("step io write + back-to-back ram read done");

    // unmapped read -> immediate error response
    request(1'b0, 32'h00005000, 32'h0, 4'b0000);
    tick();
    check("unmap_c1_ready", 32'(mem_ready), 32'h1);
    check("unmap_c1_rdata", mem_rdata, 32'hDEADBEEF);
    check("unmap_c1_enable", 32'(s_enable), 32'h0);
    check("unmap_c1_error", 32'(bus_error), 32'h1);
    check("unmap_c1_err_addr", err_addr, 32'h00005000);
    idle_cpu();
    tick();
    check("unmap_c2_ready", 32'(mem_ready), 32'h0);
    check("unmap_c2_sticky", 32'(bus_error), 32'h1);
    $display("step unmapped err_addr=%h", err_addr);

    // instruction fetch from ram is forbidden; first error address kept
    request(1'b1, 32'h00001000, 32'h0, 4'b0000);
    tick();
    check("perm_c1_ready", 32'(mem_ready), 32'h1);
    check("perm_c1_rdata", mem_rdata, 32'hDEADBEEF);
    check("perm_c1_enable", 32'(s_enable), 32'h0);
    check("perm_c1_err_addr", err_addr, 32'h00005000);
    idle_cpu();
    tick();
    $display("step forbidden fetch done");

    // ram read with no ready -> 8 enable cycles then error
    request(1'b0, 32'h00001008, 32'h0, 4'b0000);
    for (int c = 1; c <= 8; c++) begin
      tick();
      check($sformatf("tmo_c%0d_enable", c), 32'(s_enable), 32'h2);
      check($sformatf("tmo_c%0d_ready", c), 32'(mem_ready), 32'h0);
    end
    tick();
    check("tmo_c9_enable", 32'(s_enable), 32'h0);
    check("tmo_c9_ready", 32'(mem_ready), 32'h1);
    check("tmo_c9_rdata", mem_rdata, 32'hDEADBEEF);
    idle_cpu();
    tick();
    check("tmo_c10_ready", 32'(mem_ready), 32'h0);
    $display("step timeout done");

    // CPU abandons the access
    request(1'b0, 32'h10000002, 32'h0, 4'b0000);
    tick();
    check("abort_c1_enable", 32'(s_enable), 32'h4);
    check("abort_c1_addr", s_addr, 32'h2);
    idle_cpu();
    tick();
    check("abort_c2_enable", 32'(s_enable), 32'h0);
    check("abort_c2_ready", 32'(mem_ready), 32'h0);
    tick();
    check("abort_c3_ready", 32'(mem_ready), 32'h0);
    $display("step valid drop done");

    // reset in the second ACCESS cycle, then a normal access
    request(1'b0, 32'h0000100C, 32'h0, 4'b0000);
    tick();
    check("rst_mid_c1_enable", 32'(s_enable), 32'h2);
    tick();
    reset_in = 1'b1;
    tick();
    check("rst_mid_c3_enable", 32'(s_enable), 32'h0);
    check("rst_mid_c3_ready", 32'(mem_ready), 32'h0);
    check("rst_mid_c3_error", 32'(bus_error), 32'h0);
    check("rst_mid_c3_err_addr", err_addr, 32'h0);
    check("rst_mid_c3_addr", s_addr, 32'h0);
    check("rst_mid_c3_rdata", mem_rdata, 32'h0);
    reset_in = 1'b0;
    tick();
    check("rst_mid_c4_enable", 32'(s_enable), 32'h2);
    check("rst_mid_c4_addr", s_addr, 32'hC);
    s_ready = 4'b0010;
    tick();
    check("rst_mid_c5_ready", 32'(mem_ready), 32'h1);
    check("rst_mid_c5_rdata", mem_rdata, 32'hB0B00002);
    idle_cpu();
    tick();
    $display("step reset mid-access done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
